// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand/function select, condition codes, Cnd
// evaluation, E->M pipeline register and e_valE/e_dstE forwarding taps.

module alu64bit (
  input  logic [1:0]  control_input,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic [63:0] result,
  output logic        overflow
);
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control_input)
      2'd0: begin
        result   = A + B;
        overflow = (A[63] == B[63]) && (result[63] != A[63]);
      end
      2'd1: begin
        result   = A - B;
        overflow = (A[63] != B[63]) && (result[63] != A[63]);
      end
      2'd2: result = A & B;
      default: result = A ^ B;
    endcase
  end
endmodule

module execute_stage #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic        m_stat_ok,
  input  logic        W_stat_ok,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [2:0]  cc
);
  typedef enum logic [3:0] {
    I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
    I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
  } icode_e;

  typedef enum logic [2:0] {
    S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4
  } stat_e;

  logic [63:0] w_aluA, w_aluB, w_alu_out;
  logic [1:0]  w_alufun;
  logic        w_alu_ovf;
  logic        w_set_cc;
  logic        w_zf, w_sf, w_of;
  logic        w_cond;

  always_comb begin
    w_aluA = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             w_aluA = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_aluA = E_valC;
      I_CALL, I_PUSHQ:             w_aluA = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               w_aluA = 64'd8;
      default:                     w_aluA = '0;
    endcase
  end

  always_comb begin
    w_aluB = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_aluB = E_valB;
      default: w_aluB = '0;
    endcase
  end

  assign w_alufun = (E_icode == I_OPQ) ? E_ifun[1:0] : 2'd0;

  // Operands are swapped into the ALU so that subq produces valB - valA.
  alu64bit u_alu (
    .control_input(w_alufun),
    .A            (w_aluB),
    .B            (w_aluA),
    .result       (w_alu_out),
    .overflow     (w_alu_ovf)
  );

  assign e_valE = w_alu_out;
  assign {w_zf, w_sf, w_of} = cc;

  always_comb begin
    w_cond = 1'b0;
    case (E_ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (w_sf ^ w_of) | w_zf;
      4'd2:    w_cond = w_sf ^ w_of;
      4'd3:    w_cond = w_zf;
      4'd4:    w_cond = ~w_zf;
      4'd5:    w_cond = ~(w_sf ^ w_of);
      4'd6:    w_cond = ~(w_sf ^ w_of) & ~w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign e_Cnd  = (E_icode == I_RRMOVQ || E_icode == I_JXX) ? w_cond : 1'b1;
  assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;

  assign w_set_cc = (E_icode == I_OPQ) & m_stat_ok & W_stat_ok & ~M_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (w_set_cc) begin
      cc <= {(w_alu_out == '0), w_alu_out[63], w_alu_ovf & ~w_alufun[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!M_stall && M_bubble)) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage against a behavioural Y86-64 E-stage model.

module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        m_stat_ok, W_stat_ok, M_stall, M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd;
  logic [2:0]  M_stat, cc;

  execute_stage #(.RNONE(4'hF), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat_ok(m_stat_ok), .W_stat_ok(W_stat_ok), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .M_stat(M_stat), .M_icode(M_icode),
    .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  exp_t mdl_m;
  logic zf, sf, of;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
  endtask

  function automatic exp_t bubble_val();
    exp_t b;
    b.stat = 3'd1; b.icode = 4'd1; b.cnd = 1'b0; b.vale = '0; b.vala = '0;
    b.dste = 4'hF; b.dstm = 4'hF; b.cc = 3'b000;
    return b;
  endfunction

  // Drive one cycle of E-stage inputs, check the combinational taps and queue the
  // expected M register / cc contents for after the next rising edge.
  task automatic step(input logic rn, input logic st, input logic bu, input logic mok,
                      input logic wok, input logic [2:0] stat, input logic [3:0] icode,
                      input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [3:0] de, input logic [3:0] dm);
    logic [63:0] opA, opB, vale;
    logic signed [64:0] wide;
    logic ovf, cnd;
    logic [3:0] dste;
    logic [1:0] fn;
    exp_t e;
    @(negedge clk);
    rst_n = rn; M_stall = st; M_bubble = bu; m_stat_ok = mok; W_stat_ok = wok;
    E_stat = stat; E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm;
    #1;
    case (icode)
      4'h2, 4'h6:       opA = a;
      4'h3, 4'h4, 4'h5: opA = c;
      4'h8, 4'hA:       opA = -64'sd8;
      4'h9, 4'hB:       opA = 64'd8;
      default:          opA = 64'd0;
    endcase
    opB = (icode >= 4'h4 && icode <= 4'hB && icode != 4'h7) ? b : 64'd0;
    fn = (icode == 4'h6) ? ifun[1:0] : 2'd0;
    ovf = 1'b0;
    case (fn)
      2'd0: begin wide = $signed({opB[63], opB}) + $signed({opA[63], opA});
                  vale = wide[63:0]; ovf = wide[64] != wide[63]; end
      2'd1: begin wide = $signed({opB[63], opB}) - $signed({opA[63], opA});
                  vale = wide[63:0]; ovf = wide[64] != wide[63]; end
      2'd2: vale = opB & opA;
      default: vale = opB ^ opA;
    endcase
    case (ifun)
      4'd0: cnd = 1'b1;
      4'd1: cnd = (sf != of) || zf;
      4'd2: cnd = (sf != of);
      4'd3: cnd = zf;
      4'd4: cnd = !zf;
      4'd5: cnd = (sf == of);
      4'd6: cnd = (sf == of) && !zf;
      default: cnd = 1'b0;
    endcase
    if (icode != 4'h2 && icode != 4'h7) cnd = 1'b1;
    dste = (icode == 4'h2 && !cnd) ? 4'hF : de;
    if (rn) begin
      chk("e_valE", e_valE, vale);
      chk("e_dstE", {60'd0, e_dstE}, {60'd0, dste});
      chk("e_Cnd", {63'd0, e_Cnd}, {63'd0, cnd});
    end
    if (!rn) begin
      mdl_m = bubble_val();
      {zf, sf, of} = 3'b100;
    end else begin
      if (icode == 4'h6 && mok && wok && !st)
        {zf, sf, of} = {vale == 64'd0, vale[63], ovf};
      if (!st && bu) mdl_m = bubble_val();
      else if (!st) begin
        mdl_m.stat = stat; mdl_m.icode = icode; mdl_m.cnd = cnd; mdl_m.vale = vale;
        mdl_m.vala = a; mdl_m.dste = dste; mdl_m.dstm = dm;
      end
    end
    e = mdl_m;
    e.cc = {zf, sf, of};
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("M_stat",  {61'd0, M_stat},  {61'd0, e.stat});
      chk("M_icode", {60'd0, M_icode}, {60'd0, e.icode});
      chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, e.cnd});
      chk("M_valE",  M_valE, e.vale);
      chk("M_valA",  M_valA, e.vala);
      chk("M_dstE",  {60'd0, M_dstE},  {60'd0, e.dste});
      chk("M_dstM",  {60'd0, M_dstM},  {60'd0, e.dstm});
      chk("cc",      {61'd0, cc},      {61'd0, e.cc});
    end
  end

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] a, b;
    rst_n = 1'b0; M_stall = 0; M_bubble = 0; m_stat_ok = 1; W_stat_ok = 1;
    E_stat = 3'd1; E_icode = 4'h1; E_ifun = 0; E_valA = 0; E_valB = 0; E_valC = 0;
    E_dstE = 4'hF; E_dstM = 4'hF;
    mdl_m = bubble_val(); {zf, sf, of} = 3'b100;

    // Reset held for two cycles, with a stall asserted to show reset wins.
    step(0, 1, 0, 1, 1, 3'd1, 4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF);
    step(0, 0, 0, 1, 1, 3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    // addq overflow, subq to zero, cmove/cmovne
    step(1, 0, 0, 1, 1, 3'd1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF);
    step(1, 0, 0, 1, 1, 3'd1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
    step(1, 0, 0, 1, 1, 3'd1, 4'h2, 4'h3, 64'hAB, 64'd0, 64'd0, 4'h3, 4'hF);
    step(1, 0, 0, 1, 1, 3'd1, 4'h2, 4'h4, 64'hAB, 64'd0, 64'd0, 4'h3, 4'hF);
    // xorq with W not AOK: no CC update
    step(1, 0, 0, 1, 0, 3'd1, 4'h6, 4'h3, 64'hF0F0, 64'hFF00, 64'd0, 4'h5, 4'hF);
    // pushq / ret / call
    step(1, 0, 0, 1, 1, 3'd1, 4'hA, 4'h0, 64'h1234, 64'h100, 64'd0, 4'h4, 4'hF);
    step(1, 0, 0, 1, 1, 3'd1, 4'h9, 4'h0, 64'h5678, 64'hF8, 64'd0, 4'h4, 4'hF);
    step(1, 0, 0, 1, 1, 3'd1, 4'h8, 4'h0, 64'h40, 64'h0, 64'd0, 4'h4, 4'hF);
    // stall+bubble together hold M and block CC, then bubble alone
    step(1, 1, 1, 1, 1, 3'd1, 4'h6, 4'h1, 64'd9, 64'd2, 64'd0, 4'h1, 4'hF);
    step(1, 0, 1, 1, 1, 3'd1, 4'h6, 4'h0, 64'd9, 64'd2, 64'd0, 4'h1, 4'hF);
    // non-AOK E_stat still registers
    step(1, 0, 0, 1, 1, 3'd3, 4'h5, 4'h0, 64'd0, 64'h1000, 64'h20, 4'hF, 4'h7);

    for (int i = 0; i < 400; i++) begin
      a = pick64();
      b = ($urandom_range(0, 5) == 0) ? a : pick64();
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0), 3'($urandom_range(1, 4)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
           a, b, pick64(), 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline E stage, from the output of the E pipeline register to the M pipeline register.
- Selects the ALU operands and function, and instantiates alu64bit (control_input 0=add, 1=sub, 2=and, 3=xor).
- Owns the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX and jXX.
- Registers results into the M pipeline register and exports the combinational e_valE/e_dstE forwarding taps to the decode stage.

Parameters:
- RNONE, 4'hF, register ID meaning "no destination".
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- E_stat  in  3  status of the instruction in E: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valA  in  64  operand A.
- E_valB  in  64  operand B.
- E_valC  in  64  constant field.
- E_dstE  in  4  ALU-result destination register.
- E_dstM  in  4  memory-result destination register.
- m_stat_ok  in  1  instruction in M has stat AOK.
- W_stat_ok  in  1  instruction in W has stat AOK.
- M_stall  in  1  hold the M register.
- M_bubble  in  1  load a nop into the M register.
- e_valE  out  64  combinational ALU result (forwarding tap).
- e_dstE  out  4  combinational effective dstE (forwarding tap).
- e_Cnd  out  1  combinational condition result.
- M_stat  out  3  registered status.
- M_icode  out  4  registered instruction code.
- M_Cnd  out  1  registered condition result.
- M_valE  out  64  registered ALU result.
- M_valA  out  64  registered pass-through of valA.
- M_dstE  out  4  registered effective dstE.
- M_dstM  out  4  registered memory destination.
- cc  out  3  current {ZF,SF,OF}.

Behaviour:
- Instruction codes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- aluA source:
  - E_valA for icode 2 and 6.
  - E_valC for icode 3, 4, 5.
  - -8 for icode 8 and A.
  - +8 for icode 9 and B.
  - 0 otherwise.
- aluB source:
  - E_valB for icode 4, 5, 6, 8, 9, A, B.
  - 0 for icode 2 and 3, and for all other icodes.
- ALU function: E_ifun[1:0] when icode=6, add otherwise.
- ALU operand mapping: alu64bit A=aluB, B=aluA, so subq yields valB-valA and e_valE is the ALU output.
- Widths: all arithmetic is 64-bit two's-complement and wraps; there is no saturation.
- set_cc = (E_icode==6) & m_stat_ok & W_stat_ok & ~M_stall.
- When set_cc is high, on the clock edge:
  - ZF <= (e_valE==0).
  - SF <= e_valE[63].
  - OF <= ALU overflow; OF is 0 for and/xor.
- Cnd is evaluated from the cc value before this instruction's update:
  - ifun 0: always.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - ifun 7–F: 0.
- e_Cnd is forced to 1 for all icodes other than 2 and 7.
- e_dstE = RNONE when icode=2 and e_Cnd=0, otherwise E_dstE.
- M register, on the clock edge, in priority order:
  - rst_n=0: load the bubble value.
  - else M_stall=1: hold; M_stall wins over a simultaneous M_bubble.
  - else M_bubble=1: load the bubble value.
  - else load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
- Bubble value: stat=1, icode=1, Cnd=0, valE=0, valA=0, dstE=RNONE, dstM=RNONE.
- Reset:
  - cc <= CC_RESET.
  - M outputs take the bubble value.
  - Reset asserted mid-stream discards the in-flight instruction and overrides stall.
- Latency: 0 cycles for the e_* outputs; 1 cycle from E_* to M_*.
- An instruction with a non-AOK E_stat still computes and registers normally; only downstream exception status suppresses the CC update.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> cc=3'b100, M_icode=1, M_stat=1, M_dstE=F, M_dstM=F, M_valE=0.
- addq overflow: icode 6, ifun 0, valA=1, valB=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'h8000_0000_0000_0000; next cycle cc={0,1,1}, M_valE matches e_valE.
- subq zero then cmove: icode 6, ifun 1, valA=valB=5 -> cc={1,0,0}; then icode 2, ifun 3, dstE=3 -> e_Cnd=1, e_dstE=3; with ifun 4 -> e_Cnd=0, e_dstE=F.
- CC suppression: icode 6, ifun 3 (xorq) with W_stat_ok=0 -> cc unchanged, M_valE=valB^valA.
- pushq/call/ret: icode A, valB=64'h100 -> e_valE=64'hF8; icode 9, valB=64'hF8 -> e_valE=64'h100; M_valA equals E_valA in both cases.
- Stall/bubble: assert M_stall and M_bubble together -> M holds and cc does not update for OPq; then M_bubble alone -> M takes the bubble value.
